// File: rtl/wall_arb_pkg.sv
// Shared constants and FSM encoding for the wall-map query arbiter.
package wall_arb_pkg;

  localparam int MAP_W_DEF = 200;
  localparam int MAP_H_DEF = 144;
  localparam int ADDR_W    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wall_query_arb_rr_pick.sv
// Combinational round-robin picker: first set request cyclically after last_grant_i.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   grant_o
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int idx;
    idx     = 0;
    any_o   = 1'b0;
    grant_o = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % NUM_REQ;
      if (req_i[IDX_W'(idx)]) begin
        any_o   = 1'b1;
        grant_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wall_query_arb.sv
// Arbitrates wall-map point queries from tanks and the bullet unit onto one map read port.
// Define WALL_ARB_BOUNDS_EN to answer off-map queries as walls without a map read.
//
// state | meaning
// IDLE  | waiting for a request; accepts the round-robin winner
// ADDR  | map read issued (map_en high, map_addr valid)
// DATA  | map bit returning; captured into rsp_hit
// RESP  | one-cycle rsp_valid pulse to the granted requester
module wall_query_arb
  import wall_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_hit,
  output logic                 map_en,
  output logic [ADDR_W-1:0]    map_addr,
  input  logic                 map_data,
  output logic                 busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef WALL_ARB_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic             hit_q, hit_d;

  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic [7:0]       x_arr [NUM_REQ];
  logic [7:0]       y_arr [NUM_REQ];
  logic             oob;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[8*g +: 8];
    assign y_arr[g] = req_y[8*g +: 8];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i       (req),
    .last_grant_i(last_q),
    .any_o       (any_req),
    .grant_o     (pick)
  );

  assign oob = (int'(x_arr[pick]) >= MAP_W) || (int'(y_arr[pick]) >= MAP_H);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          last_d  = pick;
          x_d     = x_arr[pick];
          y_d     = y_arr[pick];
          if (BOUNDS_EN && oob) begin
            hit_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        hit_d   = map_data;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      x_q     <= '0;
      y_q     <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  // Address wraps at 15 bits by construction of the operand widths.
  assign map_addr = (ADDR_W'(y_q) * ADDR_W'(MAP_W)) + ADDR_W'(x_q);
  assign map_en   = (state_q == ADDR);
  assign rsp_hit  = hit_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/wall_query_arb.md
WALL_QUERY_ARB -- requirements
Module: wall_query_arb

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (index 0,1 = tanks, 2 = bullet unit).
REQ-002 Parameter MAP_W, default 200, wall map width in pixels.
REQ-003 Parameter MAP_H, default 144, wall map height in pixels.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NUM_REQ  per-requester query request, held until its rsp_valid.
REQ-007 req_x  input  8*NUM_REQ  packed query x coordinates, requester i in bits [8i+7:8i].
REQ-008 req_y  input  8*NUM_REQ  packed query y coordinates, same packing as req_x.
REQ-009 rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse to the granted requester.
REQ-010 rsp_hit  output  1  wall result, valid while any rsp_valid bit is high.
REQ-011 map_en  output  1  wall map read enable.
REQ-012 map_addr  output  15  wall map address, y*MAP_W + x.
REQ-013 map_data  input  1  wall map bit, valid the cycle after map_en.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ADDR, DATA and RESP.
REQ-016 In IDLE with any req bit high, the block SHALL latch the grant index, x and y, then move to ADDR.
REQ-017 Grant SHALL be round-robin: first set req bit cyclically after last_grant; last_grant updates on each accept.
REQ-018 In ADDR, map_en SHALL be 1 and map_addr SHALL equal latched_y*MAP_W + latched_x, computed at 15-bit width; next state DATA.
REQ-019 In DATA, map_en SHALL be 0 and map_data SHALL be registered into rsp_hit; next state RESP.
REQ-020 In RESP, rsp_valid[grant] SHALL be 1 and all other bits 0; next state IDLE unconditionally.
REQ-021 rsp_valid SHALL rise in the 3rd cycle after the accepting edge; peak rate is one query per 4 cycles.
REQ-022 req SHALL NOT be sampled in ADDR, DATA or RESP.
REQ-023 A req bit still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-024 Coordinate changes on non-granted requesters during a transaction SHALL have no effect.
REQ-025 rsp_hit SHALL hold its last value outside RESP; consumers use it only with rsp_valid.
REQ-026 map_en SHALL be asserted in exactly one cycle per mapped query.

Reset
REQ-027 rstn low SHALL immediately force state IDLE and clear rsp_valid, rsp_hit, map_en, map_addr, busy and the latched x/y/grant; last_grant SHALL reset to NUM_REQ-1.
REQ-028 A transaction in flight when reset asserts SHALL be dropped with no rsp_valid pulse after release.

Configuration
REQ-029 With WALL_ARB_BOUNDS_EN defined, an accepted query with x>=MAP_W or y>=MAP_H SHALL go directly IDLE->RESP with rsp_hit=1 and no map_en.
REQ-030 Without WALL_ARB_BOUNDS_EN, every query SHALL take the ADDR/DATA path, with the address truncated to 15 bits and the result taken from map_data.

Structure
REQ-031 Package wall_arb_pkg SHALL hold the MAP_W/MAP_H defaults, ADDR_W=15 and the FSM state encoding.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick (inputs: req, last_grant; outputs: any, grant index), purely combinational.

Verification
REQ-033 Single request: req=3'b001, x=10, y=5, map bit 1010=1 -> map_en with addr 1010 one cycle after accept; rsp_valid=3'b001, rsp_hit=1 on the 3rd cycle.
REQ-034 Contention: req=3'b111 held, each requester dropping its req on its rsp_valid -> grants 0,1,2 in order, responses 4 cycles apart.
REQ-035 Fairness: req=3'b011 held continuously -> grants alternate 0,1,0,1 and no requester is granted twice in a row.
REQ-036 Reset in DATA: rstn low for 1 cycle -> all outputs 0, no rsp_valid afterwards, next grant goes to requester 0.
REQ-037 Bounds, macro defined: x=200, y=10 -> rsp_hit=1 in the cycle after accept, map_en never high; macro undefined -> addr 2200 issued.
REQ-038 Held req: requester 1 keeps req high after its rsp_valid with no others pending -> re-granted; new rsp_valid 4 cycles after the previous one.
